// File: rtl/result_tx_sequencer.sv
// result_tx_sequencer: converts one result word through the external BCD
// converter, then streams the digits to the UART as ASCII.
// Leading zeros are suppressed and a terminator byte follows the last digit.
// Build option: define SIGNED_EN to treat res_data as two's complement (adds a '-' prefix).
module result_tx_sequencer #(
    parameter logic [7:0]  TERM_CHAR   = 8'h0A,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        res_valid,
    input  logic [15:0] res_data,
    output logic        res_ready,
    output logic        conv_wen,
    output logic [15:0] conv_din,
    input  logic [3:0]  conv_digit,
    input  logic        conv_sending,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        err
);
    localparam int unsigned NDIG = 6;
    localparam int unsigned IW   = 3;
    localparam int unsigned TW   = $clog2(TIMEOUT_CYC);
    localparam logic [IW-1:0] LAST_IDX = IW'(NDIG - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_CAPT,
`ifdef SIGNED_EN
        S_EMIT_SIGN,
`endif
        S_EMIT_DIG,
        S_EMIT_TERM
    } state_t;

    state_t                 state_q, state_d, first_emit;
    logic [15:0]            conv_din_q, conv_din_d;
    logic [NDIG-1:0][3:0]   dig_q, dig_d;
    logic [IW-1:0]          cap_q, cap_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic                   lead_q, lead_d;
    logic                   term_q, term_d;
    logic                   tx_valid_q, tx_valid_d;
    logic [7:0]             tx_data_q, tx_data_d;
    logic                   err_q, err_d;
    logic [15:0]            mag;
    logic                   tx_free;
    logic                   skip;
    logic [3:0]             cur_dig;
    logic [7:0]             cur_ascii;

    // Next byte may be loaded when the slot is empty or being accepted now
    assign tx_free   = !tx_valid_q || tx_ready;
    assign cur_dig   = dig_q[idx_q];
    assign skip      = lead_q && (cur_dig == 4'd0) && (idx_q != LAST_IDX);
    assign cur_ascii = (cur_dig > 4'd9) ? 8'h3F : 8'h30 + 8'(cur_dig);

`ifdef SIGNED_EN
    logic neg_q, neg_d;
    assign mag        = res_data[15] ? 16'(~res_data + 16'd1) : res_data;
    assign first_emit = neg_q ? S_EMIT_SIGN : S_EMIT_DIG;
`else
    assign mag        = res_data;
    assign first_emit = S_EMIT_DIG;
`endif

    assign conv_din = conv_din_q;
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign err      = err_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (res_valid) state_d = S_START;
            S_START:     state_d = S_WAIT;
            S_WAIT: begin
                if (conv_sending)           state_d = S_CAPT;
                else if (tmo_q == TMO_LAST) state_d = S_IDLE;
            end
            S_CAPT: begin
                if (!conv_sending)          state_d = S_IDLE;
                else if (cap_q == LAST_IDX) state_d = first_emit;
            end
`ifdef SIGNED_EN
            S_EMIT_SIGN: state_d = S_EMIT_DIG;
`endif
            S_EMIT_DIG:  if (tx_free && !skip && idx_q == LAST_IDX) state_d = S_EMIT_TERM;
            S_EMIT_TERM: if (term_q && tx_ready) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // State-decoded outputs and next values of the datapath registers
    always_comb begin
        res_ready  = (state_q == S_IDLE);
        busy       = (state_q != S_IDLE);
        conv_wen   = (state_q == S_START);
        conv_din_d = conv_din_q;
        dig_d      = dig_q;
        cap_d      = cap_q;
        idx_d      = idx_q;
        tmo_d      = tmo_q;
        lead_d     = lead_q;
        term_d     = term_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        err_d      = 1'b0;
`ifdef SIGNED_EN
        neg_d      = neg_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (res_valid) begin
                    conv_din_d = mag;
                    cap_d      = '0;
                    idx_d      = '0;
                    lead_d     = 1'b1;
                    term_d     = 1'b0;
`ifdef SIGNED_EN
                    neg_d      = res_data[15];
`endif
                end
            end
            S_START: tmo_d = '0;
            S_WAIT: begin
                if (conv_sending) begin
                    dig_d[0] = conv_digit;
                    cap_d    = IW'(1);
                end else begin
                    tmo_d = tmo_q + TW'(1);
                    if (tmo_q == TMO_LAST) err_d = 1'b1;
                end
            end
            S_CAPT: begin
                if (conv_sending) begin
                    dig_d[cap_q] = conv_digit;
                    cap_d        = cap_q + IW'(1);
                end else begin
                    err_d = 1'b1;
                end
            end
`ifdef SIGNED_EN
            S_EMIT_SIGN: begin
                tx_valid_d = 1'b1;
                tx_data_d  = 8'h2D;
            end
`endif
            S_EMIT_DIG: begin
                if (tx_free) begin
                    if (skip) begin
                        tx_valid_d = 1'b0;
                        idx_d      = idx_q + IW'(1);
                    end else begin
                        tx_valid_d = 1'b1;
                        tx_data_d  = cur_ascii;
                        lead_d     = 1'b0;
                        if (idx_q != LAST_IDX) idx_d = idx_q + IW'(1);
                    end
                end
            end
            S_EMIT_TERM: begin
                if (!term_q) begin
                    if (tx_free) begin
                        tx_valid_d = 1'b1;
                        tx_data_d  = TERM_CHAR;
                        term_d     = 1'b1;
                    end
                end else if (tx_ready) begin
                    tx_valid_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Datapath and registered output flops
    always_ff @(posedge clk) begin
        if (rst) begin
            conv_din_q <= '0;
            dig_q      <= '0;
            cap_q      <= '0;
            idx_q      <= '0;
            tmo_q      <= '0;
            lead_q     <= 1'b0;
            term_q     <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            err_q      <= 1'b0;
`ifdef SIGNED_EN
            neg_q      <= 1'b0;
`endif
        end else begin
            conv_din_q <= conv_din_d;
            dig_q      <= dig_d;
            cap_q      <= cap_d;
            idx_q      <= idx_d;
            tmo_q      <= tmo_d;
            lead_q     <= lead_d;
            term_q     <= term_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            err_q      <= err_d;
`ifdef SIGNED_EN
            neg_q      <= neg_d;
`endif
        end
    end

endmodule
